// File: rtl/gtp_block_arb.sv
// Round-robin block arbiter: pulls whole blocks from NCH gtpfifo sources onto one MIG write port.
// Defining GTPARB_CHK_EN builds the CW channel-number check that drives chk_err.
module gtp_block_arb #(
    parameter int NCH    = 4,
    parameter int CHBASE = 0
) (
    input  logic             gtp_clk,
    input  logic             rst,
    input  logic             enable,
    output logic [NCH-1:0]   give,
    input  logic [NCH-1:0]   have,
    input  logic [31:0]      data,
    output logic [31:0]      out_dat,
    output logic             out_wr,
    input  logic             out_afull,
    output logic [3:0]       cur_ch,
    output logic             blk_done,
    output logic             err,
    output logic             chk_err
);
    typedef enum logic [0:0] {POLL = 1'b0, BODY = 1'b1} state_t;

    localparam logic [3:0] LAST_CH = 4'(NCH - 1);

    state_t     state_r, state_s;
    logic [3:0] ptr_r, ptr_s, ptr_inc_s;
    logic [7:0] remain_r, remain_s;
    logic       go_s, have_sel_s, wr_s, done_s, err_s, chk_s;

    generate
        if (NCH < 1 || NCH > 16 || CHBASE < 0) begin : g_bad_cfg
            $error("gtp_block_arb: NCH must be 1..16 and CHBASE non-negative");
        end
    endgenerate

`ifdef GTPARB_CHK_EN
    logic [5:0] exp_cw_ch_s;
    assign exp_cw_ch_s = 6'(CHBASE) + {2'b00, ptr_r};
`endif

    assign cur_ch    = ptr_r;
    assign ptr_inc_s = (ptr_r == LAST_CH) ? 4'd0 : ptr_r + 4'd1;

    // One-hot read request to the pointed source and its have response.
    always_comb begin
        go_s       = ~out_afull & ((state_r == BODY) | ((state_r == POLL) & enable));
        give       = '0;
        have_sel_s = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (ptr_r == 4'(i)) begin
                give[i]    = go_s;
                have_sel_s = have[i];
            end else begin
                give[i]    = 1'b0;
            end
        end
    end

    // Next-state, pointer and pulse decode.
    always_comb begin
        state_s  = state_r;
        ptr_s    = ptr_r;
        remain_s = remain_r;
        wr_s     = 1'b0;
        done_s   = 1'b0;
        err_s    = 1'b0;
        chk_s    = 1'b0;
        case (state_r)
            POLL: begin
                if (!go_s) begin
                    ptr_s = ptr_r;
                end else if (!have_sel_s) begin
                    ptr_s = ptr_inc_s;
                end else if (data[15]) begin
                    wr_s     = 1'b1;
                    remain_s = data[8:1];
`ifdef GTPARB_CHK_EN
                    chk_s    = (data[14:9] != exp_cw_ch_s);
`endif
                    if (data[8:1] == 8'd0) begin
                        done_s = 1'b1;
                        ptr_s  = ptr_inc_s;
                    end else begin
                        state_s = BODY;
                    end
                end else begin
                    // Head without the CW marker: drop it and move on.
                    err_s = 1'b1;
                    ptr_s = ptr_inc_s;
                end
            end
            BODY: begin
                if (!go_s) begin
                    remain_s = remain_r;
                end else if (have_sel_s) begin
                    wr_s     = 1'b1;
                    remain_s = remain_r - 8'd1;
                    if (remain_r == 8'd1) begin
                        done_s  = 1'b1;
                        ptr_s   = ptr_inc_s;
                        state_s = POLL;
                    end else begin
                        state_s = BODY;
                    end
                end else begin
                    // Source ran dry inside an advertised block; abandon the rest.
                    err_s   = 1'b1;
                    ptr_s   = ptr_inc_s;
                    state_s = POLL;
                end
            end
            default: begin
                state_s = POLL;
            end
        endcase
    end

    // State and registered output path.
    always_ff @(posedge gtp_clk) begin
        if (rst) begin
            state_r  <= POLL;
            ptr_r    <= 4'd0;
            remain_r <= 8'd0;
            out_dat  <= 32'd0;
            out_wr   <= 1'b0;
            blk_done <= 1'b0;
            err      <= 1'b0;
            chk_err  <= 1'b0;
        end else begin
            state_r  <= state_s;
            ptr_r    <= ptr_s;
            remain_r <= remain_s;
            out_wr   <= wr_s;
            blk_done <= done_s;
            err      <= err_s;
            chk_err  <= chk_s;
            if (wr_s) begin
                out_dat <= data;
            end
        end
    end
endmodule

// File: tb/tb_gtp_block_arb.sv
// Self-checking bench for gtp_block_arb: directed scenarios plus randomized block traffic
// compared against a block-level round-robin model.
module tb_gtp_block_arb;
`ifdef GTPARB_CHK_EN
    localparam int CHB = 8;
    localparam int EXP_CHK = 1;
`else
    localparam int CHB = 0;
    localparam int EXP_CHK = 0;
`endif

    logic        gtp_clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        out_afull = 1'b0;
    logic [3:0]  give, have;
    logic [31:0] data, out_dat;
    logic        out_wr, blk_done, err, chk_err;
    logic [3:0]  cur_ch;

    logic [31:0] fmem [4][256];
    logic [7:0]  rd [4];
    logic [7:0]  wr [4];

    logic [31:0] got_q [$];
    int          done_pos [$];
    int          done_ch [$];
    int          err_ch [$];
    int          chk_pos [$];
    int          n_afull_give, n_afull_cyc, n_multi;
    int          n_checks = 0;
    int          n_fail = 0;

    gtp_block_arb #(.NCH(4), .CHBASE(CHB)) dut (
        .gtp_clk(gtp_clk), .rst(rst), .enable(enable), .give(give), .have(have),
        .data(data), .out_dat(out_dat), .out_wr(out_wr), .out_afull(out_afull),
        .cur_ch(cur_ch), .blk_done(blk_done), .err(err), .chk_err(chk_err)
    );

    always #5 gtp_clk = ~gtp_clk;

    // Source fifo models: answer give combinationally, pop on accepted beat.
    always_comb begin
        have = 4'b0000;
        data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (give[i] && (rd[i] != wr[i])) begin
                have[i] = 1'b1;
                data    = fmem[i][rd[i]];
            end
        end
    end

    always @(posedge gtp_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) rd[i] <= 8'd0;
            else if (give[i] && have[i]) rd[i] <= rd[i] + 8'd1;
        end
    end

    // Output monitor.
    always @(negedge gtp_clk) begin
        if (rst) begin
            got_q.delete(); done_pos.delete(); done_ch.delete(); err_ch.delete(); chk_pos.delete();
            n_afull_give = 0; n_afull_cyc = 0; n_multi = 0;
        end else begin
            if (out_wr) got_q.push_back(out_dat);
            if (blk_done) begin done_pos.push_back(got_q.size()); done_ch.push_back(int'(cur_ch)); end
            if (err) err_ch.push_back(int'(cur_ch));
            if (chk_err) chk_pos.push_back(got_q.size());
            if (out_afull) n_afull_cyc++;
            if (out_afull && give != 4'b0000) n_afull_give++;
            if ($countones(give) > 1) n_multi++;
        end
    end

    function automatic bit all_empty();
        for (int i = 0; i < 4; i++) if (rd[i] != wr[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic load(input int ch, input logic [31:0] d);
        fmem[ch][wr[ch]] = d;
        wr[ch] = wr[ch] + 8'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; out_afull = 1'b0;
        for (int i = 0; i < 4; i++) wr[i] = 8'd0;
        repeat (2) @(posedge gtp_clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain(input int budget, input bit rnd);
        int idle = 0;
        int cyc = 0;
        while (idle < 4 && cyc < budget) begin
            @(posedge gtp_clk); #1;
            if (rnd) begin
                enable    = ($urandom_range(0, 4) != 0);
                out_afull = ($urandom_range(0, 3) == 0);
            end
            cyc++;
            if (all_empty()) idle++; else idle = 0;
        end
        enable = 1'b1; out_afull = 1'b0;
        repeat (3) @(posedge gtp_clk); #1;
        n_checks++;
        if (idle < 4) begin n_fail++; $display("FAIL drain_timeout: got %0d cycles, required drain within %0d", cyc, budget); end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({out_wr, blk_done, err, chk_err, give, cur_ch, out_dat} !== {4'b0000, 4'b0000, 4'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got wr=%b done=%b err=%b chk=%b give=%b ch=%0d dat=%h required all 0",
                     out_wr, blk_done, err, chk_err, give, cur_ch, out_dat);
        end
        load(0, 32'h0000_8012);
        for (int k = 0; k < 9; k++) load(0, 32'hA000_0000 + k);
        enable = 1'b1;
        repeat (4) @(posedge gtp_clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge gtp_clk); #1;
            n_checks++;
            if (out_wr !== 1'b0 || cur_ch !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_midblock: got wr=%b ch=%0d required wr=0 ch=0", out_wr, cur_ch);
            end
        end
    endtask

    task automatic test_single_block();
        do_reset();
        load(1, 32'h0000_8003);
        load(1, 32'hCAFE_0001);
        enable = 1'b1;
        @(negedge gtp_clk);
        n_checks++;
        if (give !== 4'b0001) begin n_fail++; $display("FAIL poll_ch0: got give=%b required 0001", give); end
        @(negedge gtp_clk);
        n_checks++;
        if (give !== 4'b0010) begin n_fail++; $display("FAIL poll_ch1: got give=%b required 0010", give); end
        drain(200, 1'b0);
        n_checks++;
        if (got_q.size() != 2 || got_q[0] !== 32'h0000_8003 || got_q[1] !== 32'hCAFE_0001) begin
            n_fail++; $display("FAIL single_data: got %0d words required 8003,cafe0001", got_q.size());
        end
        n_checks++;
        if (done_pos.size() != 1 || done_pos[0] != 2 || done_ch[0] != 2 || err_ch.size() != 0) begin
            n_fail++; $display("FAIL single_done: got %0d pulses required 1 on word 2 with ptr 2", done_pos.size());
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int ch = 0; ch < 4; ch++) load(ch, {16'(ch), 16'h8001});
        enable = 1'b1;
        drain(200, 1'b0);
        n_checks++;
        if (got_q.size() != 4) begin
            n_fail++; $display("FAIL rr_count: got %0d words required 4", got_q.size());
        end else begin
            for (int ch = 0; ch < 4; ch++) begin
                n_checks++;
                if (got_q[ch] !== {16'(ch), 16'h8001}) begin
                    n_fail++; $display("FAIL rr_order: got %h required %h", got_q[ch], {16'(ch), 16'h8001});
                end
            end
        end
        n_checks++;
        if (done_pos.size() != 4 || err_ch.size() != 0) begin
            n_fail++; $display("FAIL rr_pulses: got done=%0d err=%0d required 4 and 0", done_pos.size(), err_ch.size());
        end
    endtask

    task automatic test_afull();
        int cyc = 0;
        do_reset();
        load(0, 32'h0000_8012);
        for (int k = 0; k < 9; k++) load(0, 32'hB0D0_0000 + k);
        enable = 1'b1;
        while (got_q.size() < 3 && cyc < 100) begin @(posedge gtp_clk); #1; cyc++; end
        out_afull = 1'b1;
        repeat (5) @(posedge gtp_clk);
        #1 out_afull = 1'b0;
        drain(200, 1'b0);
        n_checks++;
        if (n_afull_cyc != 5 || n_afull_give != 0) begin
            n_fail++; $display("FAIL afull_give: got %0d afull cycles with %0d give required 5 and 0", n_afull_cyc, n_afull_give);
        end
        n_checks++;
        if (got_q.size() != 10 || err_ch.size() != 0 || done_pos.size() != 1) begin
            n_fail++; $display("FAIL afull_count: got %0d words err=%0d required 10 words no err", got_q.size(), err_ch.size());
        end else begin
            for (int k = 1; k < 10; k++) begin
                n_checks++;
                if (got_q[k] !== 32'hB0D0_0000 + 32'(k - 1)) begin
                    n_fail++; $display("FAIL afull_data: got %h required %h", got_q[k], 32'hB0D0_0000 + 32'(k - 1));
                end
            end
        end
    endtask

    task automatic test_bad_head();
        do_reset();
        load(2, 32'h0000_1234);
        enable = 1'b1;
        drain(200, 1'b0);
        n_checks++;
        if (got_q.size() != 0 || err_ch.size() != 1 || err_ch[0] != 3) begin
            n_fail++; $display("FAIL bad_head: got words=%0d err=%0d required 0 words, 1 err then ch3", got_q.size(), err_ch.size());
        end
    endtask

    task automatic test_short_block();
        do_reset();
        load(1, 32'h0000_800A);
        for (int k = 0; k < 3; k++) load(1, 32'h5150_0000 + k);
        load(2, 32'h0000_8001);
        enable = 1'b1;
        drain(200, 1'b0);
        n_checks++;
        if (got_q.size() != 5 || got_q[0] !== 32'h0000_800A || got_q[3] !== 32'h5150_0002 || got_q[4] !== 32'h0000_8001) begin
            n_fail++; $display("FAIL short_data: got %0d words required 4 then ch2 head", got_q.size());
        end
        n_checks++;
        if (err_ch.size() != 1 || err_ch[0] != 2 || done_pos.size() != 1 || done_pos[0] != 5 || done_ch[0] != 3) begin
            n_fail++; $display("FAIL short_pulses: got err=%0d done=%0d required 1 err to ch2, done only for ch2", err_ch.size(), done_pos.size());
        end
    endtask

    task automatic test_chk();
        do_reset();
        load(1, 32'h0000_9201);
        load(1, 32'h0000_9801);
        enable = 1'b1;
        drain(200, 1'b0);
        n_checks++;
        if (got_q.size() != 2 || done_pos.size() != 2) begin
            n_fail++; $display("FAIL chk_forward: got %0d words required 2", got_q.size());
        end
        n_checks++;
        if (chk_pos.size() != EXP_CHK || (EXP_CHK == 1 && chk_pos[0] != 2)) begin
            n_fail++; $display("FAIL chk_err: got %0d pulses required %0d on second block", chk_pos.size(), EXP_CHK);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_q [$];
        logic [31:0] hd;
        int pos [4];
        int exp_done, exp_err, ptr, nb, len;
        bit pending;
        for (int it = 0; it < 12; it++) begin
            do_reset();
            for (int ch = 0; ch < 4; ch++) begin
                nb = $urandom_range(0, 3);
                for (int b = 0; b < nb; b++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        hd = $urandom; hd[15] = 1'b0; load(ch, hd);
                    end else begin
                        len = $urandom_range(0, 6);
                        load(ch, {16'($urandom), 1'b1, 6'($urandom), 8'(len), 1'($urandom)});
                        for (int k = 0; k < len; k++) load(ch, $urandom);
                    end
                end
            end
            // Model: each visit to a non-empty source takes one whole block or one bad head.
            exp_q.delete(); exp_done = 0; exp_err = 0; ptr = 0;
            for (int ch = 0; ch < 4; ch++) pos[ch] = 0;
            pending = !all_empty();
            while (pending) begin
                if (pos[ptr] < int'(wr[ptr])) begin
                    hd = fmem[ptr][pos[ptr]];
                    if (hd[15]) begin
                        for (int k = 0; k <= int'(hd[8:1]); k++) exp_q.push_back(fmem[ptr][pos[ptr] + k]);
                        pos[ptr] += int'(hd[8:1]) + 1;
                        exp_done++;
                    end else begin
                        pos[ptr]++;
                        exp_err++;
                    end
                end
                ptr = (ptr + 1) % 4;
                pending = 1'b0;
                for (int ch = 0; ch < 4; ch++) if (pos[ch] < int'(wr[ch])) pending = 1'b1;
            end
            enable = 1'b1;
            drain(3000, 1'b1);
            n_checks++;
            if (got_q.size() != exp_q.size() || done_pos.size() != exp_done || err_ch.size() != exp_err) begin
                n_fail++;
                $display("FAIL rand_counts it%0d: got words=%0d done=%0d err=%0d required %0d %0d %0d",
                         it, got_q.size(), done_pos.size(), err_ch.size(), exp_q.size(), exp_done, exp_err);
            end else begin
                for (int k = 0; k < exp_q.size(); k++) begin
                    n_checks++;
                    if (got_q[k] !== exp_q[k]) begin
                        n_fail++; $display("FAIL rand_data it%0d word %0d: got %h required %h", it, k, got_q[k], exp_q[k]);
                    end
                end
            end
            n_checks++;
            if (n_multi != 0 || n_afull_give != 0) begin
                n_fail++; $display("FAIL rand_give it%0d: got multi=%0d afull_give=%0d required 0 and 0", it, n_multi, n_afull_give);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) wr[i] = 8'd0;
        test_reset();
        test_single_block();
        test_round_robin();
        test_afull();
        test_bad_head();
        test_short_block();
        test_chk();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gtp_block_arb.md
Name:
gtp_block_arb

Overview:
Round-robin block arbiter directly downstream of the per-link gtpfifo instances. Pulls whole blocks, never interleaved, from NCH fifos using their give/have handshake and a shared 32-bit read bus. Streams the dwords into a single write port feeding the MIG write FIFO. Honours downstream almost-full, and flags malformed or short blocks.

Parameters:
NCH, 4, number of gtpfifo sources (1..16)
CHBASE, 0, channel number expected in the CW of source 0 (used only with GTPARB_CHK_EN)

Ports:
gtp_clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
enable  in  1  arbitration enable; when low, no new block is started
give  out  NCH  one-hot read request to fifo[i]
have  in  NCH  fifo[i] has valid data on data; combinational response to give
data  in  32  shared read bus; driven only by the fifo answering have
out_dat  out  32  dword to MIG write FIFO
out_wr  out  1  write strobe for out_dat
out_afull  in  1  downstream has 2 or fewer free entries
cur_ch  out  4  index of the source currently granted
blk_done  out  1  one-cycle pulse when the last dword of a block is written
err  out  1  one-cycle pulse on a protocol error
chk_err  out  1  one-cycle pulse on a CW channel mismatch (optional feature)

Behaviour:
- Reset values: give=0, out_dat=0, out_wr=0, cur_ch=0, blk_done=0, err=0, chk_err=0, state=POLL, ptr=0, remain=0.
- give is combinational:
  - give[i] = (i==ptr) & ~out_afull & (state==BODY | (state==POLL & enable)).
  - At most one bit is high at any time.
- A beat is accepted when give[ptr] & have[ptr] in the same cycle. The fifo advances its read pointer on that same edge.
- Output path:
  - out_dat <= data and out_wr <= 1 on the edge after an accepted beat; out_wr <= 0 otherwise.
  - Latency from beat to out_wr is 1 cycle.
- FSM states: POLL, BODY.
- POLL:
  - No beat (have[ptr]=0, or give suppressed by out_afull or !enable):
    - If give was suppressed, ptr is held.
    - Otherwise ptr <= (ptr+1) mod NCH. Polling costs one cycle per empty source.
  - Beat with data[15]=1 (valid CW):
    - Dword is forwarded.
    - remain <= data[8:1], the number of dwords after the head.
    - If data[8:1]==0: blk_done pulses, ptr advances, state stays POLL.
    - Otherwise: state <= BODY, ptr held.
  - Beat with data[15]=0 (bad head):
    - Dword is dropped (out_wr stays 0).
    - err pulses, ptr advances, state stays POLL.
- BODY:
  - Beat: forward the dword, remain <= remain-1.
    - If remain==1: blk_done pulses on the write cycle, ptr advances, state <= POLL.
  - give high but have low: the source under-delivered a block it advertised as complete.
    - err pulses, remaining dwords are abandoned, ptr advances, state <= POLL.
  - out_afull high: give held low, state and remain held. No error is raised.
- enable going low during BODY does not stop the current block; it only prevents a new head from starting.
- Wrap: ptr wraps from NCH-1 to 0.
- cur_ch = ptr, zero-extended to 4 bits.
- Reset mid-block: immediate return to POLL with ptr=0. No output is written on the reset cycle or the cycle after. The upstream fifos are reset by the same rst.
- Arithmetic: remain is 8 bits. Maximum block is 256 dwords including the head.

Optional Feature:
- Macro: GTPARB_CHK_EN.
- With the macro defined: on every accepted head, data[14:9] is compared with (CHBASE+ptr) mod 64. On mismatch, chk_err pulses on the output-write cycle; the block is still forwarded normally.
- Without the macro: no comparator is built and chk_err is tied to 0.

Test Plan:
1. Reset, then fifo1 holds block CW=0x8003 (data[8:1]=1, 2 dwords) and all others are empty. Expect a poll of ch0 then ch1, 2 out_wr beats (0x????8003, then the body dword), blk_done on the second beat, and ptr=2 afterwards.
2. All 4 fifos hold a 1-dword block (CW 0x8001) each. Expect output in order ch0, ch1, ch2, ch3, 4 blk_done pulses, and no err.
3. 10-dword block with out_afull forced high for 5 cycles mid-body. Expect give low for those 5 cycles, no err, and all 10 dwords delivered in order with no duplicates.
4. Head dword 0x00001234 (bit15=0) on ch2. Expect no out_wr, 1 err pulse, and the arbiter moving to ch3.
5. Block CW with data[8:1]=5 whose source drops have after 3 body beats. Expect 4 dwords written, err pulse, no blk_done, and return to POLL on the next source.
6. With GTPARB_CHK_EN defined and CHBASE=8: ch1 delivers CW channel 9, then CW channel 12. Expect chk_err low for the first block and one pulse for the second; both blocks forwarded.
